// File: rtl/roll_button_ctrl.sv
// Roll-button front end: synchronizes and debounces two raw buttons, then
// sequences die-1 / die-2 roll requests as single-cycle registered pulses.
module roll_button_ctrl #(
  parameter int unsigned DB_CYCLES = 12000
) (
  input  logic CLK,
  input  logic reset,
  input  logic btn1,
  input  logic btn2,
  input  logic roll_en,
  output logic Rb1,
  output logic Rb2,
  output logic busy
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned N_BTN = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM2 = 2'd1,
    HOLD = 2'd2
  } state_t;

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] sync_q1;
  logic [N_BTN-1:0] sync_q2;
  logic [N_BTN-1:0] deb_q;
  logic [N_BTN-1:0] deb_d;
  logic [N_BTN-1:0] press;
  logic [CNT_W-1:0] cnt_q [N_BTN];

  state_t state;
  state_t state_n;
  logic   rb1_n;
  logic   rb2_n;

  assign btn_raw = {btn2, btn1};

  // Synchronizers, debounce counters and the delayed level for edge detection
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      deb_q   <= '0;
      deb_d   <= '0;
      for (int i = 0; i < int'(N_BTN); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
      deb_d   <= deb_q;
      for (int i = 0; i < int'(N_BTN); i++) begin
        if (sync_q2[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          deb_q[i] <= sync_q2[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Only a debounced rise is a press; a held level never repeats
  assign press = deb_q & ~deb_d;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      Rb1   <= 1'b0;
      Rb2   <= 1'b0;
    end else begin
      state <= state_n;
      Rb1   <= rb1_n;
      Rb2   <= rb2_n;
    end
  end

  always_comb begin
    state_n = state;
    rb1_n   = 1'b0;
    rb2_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (press[0] && roll_en) begin
          rb1_n   = 1'b1;
          state_n = ARM2;
        end
      end
      ARM2: begin
        if (press[1]) begin
          rb2_n   = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (deb_q == '0) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_roll_button_ctrl.sv
// Bench for roll_button_ctrl: directed scenarios plus random button traffic,
// with a reference model feeding an expected-pulse scoreboard.
module tb_roll_button_ctrl;

  localparam int unsigned DB = 4;

  logic CLK = 1'b0;
  logic reset;
  logic btn1;
  logic btn2;
  logic roll_en;
  logic Rb1;
  logic Rb2;
  logic busy;

  always #5 CLK = ~CLK;

  roll_button_ctrl #(.DB_CYCLES(DB)) dut (
    .CLK     (CLK),
    .reset   (reset),
    .btn1    (btn1),
    .btn2    (btn2),
    .roll_en (roll_en),
    .Rb1     (Rb1),
    .Rb2     (Rb2),
    .busy    (busy)
  );

  typedef struct {
    int cyc;
    int which;
  } pulse_t;

  pulse_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state: delayed samples, stable-run lengths, accepted level,
  // pending press flag, and how far through the two-roll sequence we are.
  bit m_s1   [2];
  bit m_s2   [2];
  bit m_deb  [2];
  bit m_rose [2];
  int m_run  [2];
  int m_step;
  bit exp_busy;

  function automatic void chk(string nm, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (cycle %0d, t=%0t)", nm, got, want, cyc, $time);
    end
  endfunction

  // Reference model: a level is accepted after DB consecutive disagreeing
  // samples seen two cycles late; the roll request appears the cycle after
  // the press is seen.
  always @(posedge CLK or negedge reset) begin : model
    bit raw [2];
    bit p1, p2;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_deb[i] = 1'b0;
        m_rose[i] = 1'b0; m_run[i] = 0;
      end
      m_step   = 0;
      exp_busy = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      raw[0] = btn1;
      raw[1] = btn2;
      p1 = m_rose[0];
      p2 = m_rose[1];
      if (m_step == 0) begin
        if (p1 && roll_en) begin
          exp_q.push_back('{cyc: cyc, which: 1});
          m_step = 1;
        end
      end else if (m_step == 1) begin
        if (p2) begin
          exp_q.push_back('{cyc: cyc, which: 2});
          m_step = 2;
        end
      end else if (!m_deb[0] && !m_deb[1]) begin
        m_step = 0;
      end
      for (int i = 0; i < 2; i++) begin
        m_rose[i] = 1'b0;
        if (m_s2[i] != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == int'(DB)) begin
            m_deb[i]  = m_s2[i];
            m_rose[i] = m_s2[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
      end
      exp_busy = (m_step != 0);
    end
  end

  // Monitor: compares busy every cycle and matches each DUT pulse to the queue
  always @(negedge CLK) begin : monitor
    pulse_t e;
    chk("busy", int'(busy), int'(exp_busy));
    chk("rb_exclusive", int'(Rb1 & Rb2), 0);
    if (Rb1 || Rb2) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rb_unexpected: got Rb1=%0b Rb2=%0b at cycle %0d, no pulse expected", Rb1, Rb2, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rb_which", Rb2 ? 2 : 1, e.which);
        chk("rb_cycle", cyc, e.cyc);
      end
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        n_err++;
        $display("FAIL rb_missing: no pulse at cycle %0d, required Rb%0d due at cycle %0d", cyc, e.which, e.cyc);
      end
    end
  end

  // Inputs change 1 time unit after a rising edge, then hold n cycles
  task automatic drive(input logic b1, input logic b2, input logic en, input int n);
    btn1    = b1;
    btn2    = b2;
    roll_en = en;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset(input int n);
    @(posedge CLK);
    #3 reset = 1'b0;
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_rb1", int'(Rb1), 0);
    chk("reset_rb2", int'(Rb2), 0);
    repeat (n) @(posedge CLK);
    #3 reset = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    btn1    = 1'b0;
    btn2    = 1'b0;
    roll_en = 1'b0;
    #1;
    chk("init_busy", int'(busy), 0);
    chk("init_rb1", int'(Rb1), 0);
    chk("init_rb2", int'(Rb2), 0);
    repeat (2) @(posedge CLK);
    #3 reset = 1'b1;
    @(posedge CLK);
    #1;

    // Clean press, then die-2 press, release both
    drive(1, 0, 1, 10);
    drive(0, 0, 1, 10);
    drive(0, 1, 1, 10);
    drive(1, 1, 1, 6);
    drive(0, 0, 1, 12);

    // Bounce on btn1 before a stable hold
    drive(1, 0, 1, 1);
    drive(0, 0, 1, 1);
    drive(1, 0, 1, 1);
    drive(0, 0, 1, 1);
    drive(1, 0, 1, 12);
    drive(0, 0, 1, 10);
    drive(0, 1, 1, 2);
    drive(0, 0, 1, 2);
    drive(0, 1, 1, 10);
    drive(0, 0, 1, 12);

    // Die-2 first is ignored, then normal order
    drive(0, 1, 1, 10);
    drive(0, 0, 1, 10);
    drive(1, 0, 1, 10);
    drive(0, 0, 1, 10);
    drive(0, 1, 1, 10);
    drive(0, 0, 1, 12);

    // Lockout: press while disabled, enable while held, then re-press
    drive(1, 0, 0, 10);
    drive(1, 0, 1, 10);
    drive(0, 0, 1, 10);
    drive(1, 0, 1, 10);
    drive(0, 0, 1, 10);
    drive(0, 1, 1, 10);
    drive(0, 0, 1, 12);

    // Simultaneous rise
    drive(1, 1, 1, 10);
    drive(0, 0, 1, 10);
    drive(0, 1, 1, 10);
    drive(0, 0, 1, 12);

    // Async reset in ARM2 with btn2 pressed during reset; btn1 held through reset
    drive(1, 0, 1, 10);
    drive(0, 0, 1, 4);
    chk("arm2_busy", int'(busy), 1);
    btn2 = 1'b1;
    pulse_reset(2);
    drive(0, 1, 1, 12);
    drive(0, 0, 1, 10);
    drive(1, 0, 1, 2);
    btn1 = 1'b1;
    pulse_reset(1);
    drive(1, 0, 1, 12);
    drive(0, 0, 1, 10);
    drive(0, 1, 1, 10);
    drive(1, 1, 1, 20);
    drive(0, 0, 1, 12);

    // Random traffic
    repeat (300) begin
      if ($urandom_range(0, 40) == 0) begin
        pulse_reset(int'($urandom_range(1, 3)));
      end else begin
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 7) != 0), int'($urandom_range(1, 9)));
      end
    end

    drive(0, 0, 1, 20);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/roll_button_ctrl.md
ROLL_BUTTON_CTRL -- requirements
Module: roll_button_ctrl

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 12000: consecutive stable samples required to accept a button level change (legal range 2..65535).
REQ-002 The block SHALL have port CLK  input  1  single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port btn1  input  1  raw, asynchronous, bouncing roll button for die 1.
REQ-005 The block SHALL have port btn2  input  1  raw, asynchronous, bouncing roll button for die 2.
REQ-006 The block SHALL have port roll_en  input  1  high while the game accepts rolls (driven from game Roll status).
REQ-007 The block SHALL have port Rb1  output  1  one-cycle roll request for die 1.
REQ-008 The block SHALL have port Rb2  output  1  one-cycle roll request for die 2.
REQ-009 The block SHALL have port busy  output  1  high whenever the sequencer is not in IDLE.

Function
REQ-010 Each btn SHALL pass through a 2-flop synchronizer before any other logic; latency input-to-synchronized is 2 cycles.
REQ-011 Each synchronized button SHALL have its own 16-bit debounce counter: clears when sync level equals debounced level, else increments; at DB_CYCLES-1 the debounced level takes the sync level and the counter clears.
REQ-012 A glitch shorter than DB_CYCLES cycles SHALL never change the debounced level.
REQ-013 A debounced 0->1 transition SHALL be a press event, valid for exactly one cycle; 1->0 is a release, never a press.
REQ-014 Sequencer states SHALL be IDLE, ARM2, HOLD; the reset state is IDLE.
REQ-015 IDLE: press1 with roll_en=1 -> Rb1=1 for that one cycle, go ARM2; press2 ignored; press1 with roll_en=0 ignored.
REQ-016 ARM2: press2 -> Rb2=1 for that one cycle, go HOLD; further press1 ignored; roll_en is not checked in ARM2.
REQ-017 HOLD: stays until both debounced levels are 0, then go IDLE the next cycle.
REQ-018 Simultaneous press1 and press2 in IDLE SHALL give Rb1 only and move to ARM2; Rb2 then needs a fresh press2 after release.
REQ-019 Rb1 and Rb2 SHALL never both be 1 in the same cycle, and each SHALL be high for exactly one cycle per accepted press.
REQ-020 A button held continuously SHALL produce at most one press event, no auto-repeat.
REQ-021 busy SHALL be combinational from state: 0 in IDLE, 1 in ARM2 and HOLD.
REQ-022 Rb1/Rb2 SHALL be registered outputs, asserted the cycle after the press-event cycle.

Reset
REQ-023 reset=0 SHALL immediately, without a clock edge, force Rb1=0, Rb2=0, busy=0, state=IDLE, synchronizers=0, debounced levels=0, counters=0.
REQ-024 Reset asserted mid-sequence (ARM2 or HOLD) SHALL abandon the sequence; a button still held at release of reset SHALL give a press after 2+DB_CYCLES cycles.
REQ-025 Reset deassertion SHALL take effect on the first CLK rising edge after reset returns to 1.

Verification (DB_CYCLES=4 in the bench)
REQ-026 Clean press: roll_en=1, btn1 held 10 cycles -> Rb1 pulses once, 1 cycle wide, 7 cycles (2 sync + 4 debounce + 1 register) after the btn1 rise; busy=1 from then on.
REQ-027 Bounce: btn1 toggles 1,0,1,0 one cycle each, then held -> no Rb1 during bounce; exactly one Rb1 pulse DB_CYCLES stable cycles after the final rise.
REQ-028 Order: btn2 pressed in IDLE -> no Rb2; then btn1 press -> Rb1; then btn2 press -> Rb2; release both -> busy=0 after debounce plus 1 cycle.
REQ-029 Lockout: roll_en=0, btn1 press -> no Rb1, busy stays 0; roll_en=1 while btn1 still held -> still no Rb1 until release and re-press.
REQ-030 Simultaneous: btn1 and btn2 rise on the same cycle -> Rb1 only; Rb2 only after btn2 is released and pressed again.
REQ-031 Async reset: reset=0 mid-cycle in ARM2 -> busy=0 before the next CLK edge; no Rb2 for the pending sequence.
